// File: rtl/dff_pkg.sv
// -----------------------------------------------------------------------------
// dff_pkg
// Shared definitions for the dff_shift_reg universal register.
//   mode_e       : 3-bit operation select applied on an enabled clock edge.
//   cnt_width()  : width of the saturating shift counter for a given WIDTH.
// -----------------------------------------------------------------------------
package dff_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'd0,    // keep contents
        LOAD = 3'd1,    // parallel load from d
        SHL  = 3'd2,    // shift toward MSB, sin_l enters bit 0
        SHR  = 3'd3,    // shift toward LSB, sin_r enters MSB
        ROL  = 3'd4,    // rotate toward MSB
        ROR  = 3'd5,    // rotate toward LSB
        CLR  = 3'd6,    // all zeros
        SET  = 3'd7     // all ones
    } mode_e;

    // The counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : dff_pkg

// File: rtl/dff_cell.sv
// -----------------------------------------------------------------------------
// dff_cell
// Single-bit D flip-flop with asynchronous active-high reset.
// Parameters:
//   RST_VAL : value forced onto q_o while rst_i is high.
// Ports:
//   clk_i : rising-edge clock
//   rst_i : asynchronous reset, active high
//   d_i   : next-state input, sampled on the rising edge
//   q_o   : stored bit
// -----------------------------------------------------------------------------
module dff_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic bit_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_q <= RST_VAL;
        end else begin
            bit_q <= d_i;
        end
    end

    assign q_o = bit_q;

endmodule : dff_cell

// File: rtl/dff_shift_reg.sv
// -----------------------------------------------------------------------------
// dff_shift_reg
// WIDTH-bit universal register: hold, parallel load, clear, set, logical
// shift and rotate in both directions, serial in/out at both ends, and a
// saturating count of shifts since the last LOAD/CLR/SET.
// Parameters:
//   WIDTH   : register width, at least 2
//   RST_VAL : contents after reset
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous reset, active high
//   en      : operation enable; low freezes q and cnt
//   mode    : operation select (dff_pkg::mode_e encoding)
//   d       : parallel load data
//   sin_l   : serial input entering bit 0 on SHL
//   sin_r   : serial input entering bit WIDTH-1 on SHR
//   q       : register contents
//   sout_l  : q[WIDTH-1]
//   sout_r  : q[0]
//   cnt     : shifts since last LOAD/CLR/SET, saturating at WIDTH
//   drained : cnt == WIDTH
// -----------------------------------------------------------------------------
module dff_shift_reg
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [2:0]                    mode,
    input  logic [WIDTH-1:0]              d,
    input  logic                          sin_l,
    input  logic                          sin_r,
    output logic [WIDTH-1:0]              q,
    output logic                          sout_l,
    output logic                          sout_r,
    output logic [cnt_width(WIDTH)-1:0]   cnt,
    output logic                          drained
);

    localparam int             CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] shr_v;
    logic [WIDTH-1:0] rol_v;
    logic [WIDTH-1:0] ror_v;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    assign mode_s = mode_e'(mode);

    // Whole-vector candidates for the moving modes; each bit's mux below
    // simply picks its own position out of these.
    always_comb begin
        shl_v = {q_q[WIDTH-2:0], sin_l};
        shr_v = {sin_r, q_q[WIDTH-1:1]};
        rol_v = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        ror_v = {q_q[0], q_q[WIDTH-1:1]};
    end

    // -------------------------------------------------------------------------
    // Storage: one dff_cell per bit, each fed by its own 8:1 next-state mux.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic bit_d;

        always_comb begin
            bit_d = q_q[i];
            if (en) begin
                case (mode_s)
                    HOLD:    bit_d = q_q[i];
                    LOAD:    bit_d = d[i];
                    SHL:     bit_d = shl_v[i];
                    SHR:     bit_d = shr_v[i];
                    ROL:     bit_d = rol_v[i];
                    ROR:     bit_d = ror_v[i];
                    CLR:     bit_d = 1'b0;
                    SET:     bit_d = 1'b1;
                    default: bit_d = q_q[i];
                endcase
            end
        end

        dff_cell #(
            .RST_VAL (RST_VAL[i])
        ) u_cell (
            .clk_i (clk),
            .rst_i (rst),
            .d_i   (bit_d),
            .q_o   (q_q[i])
        );
    end

    // -------------------------------------------------------------------------
    // Shift counter: cleared by LOAD/CLR/SET, bumped by logical shifts only,
    // sticks at WIDTH. Rotates do not drain the register, so they do not count.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            case (mode_s)
                LOAD, CLR, SET: cnt_d = '0;
                SHL, SHR: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Serial outputs are taken straight from the stored bits so a downstream
    // stage sampling on the same edge sees the bit being shifted out.
    assign q       = q_q;
    assign sout_l  = q_q[WIDTH-1];
    assign sout_r  = q_q[0];
    assign cnt     = cnt_q;
    assign drained = (cnt_q == CNT_MAX);

endmodule : dff_shift_reg

// File: tb/tb_dff_shift_reg.sv
module tb_dff_shift_reg;
    import dff_pkg::*;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] d = 8'h00;
    logic       sin_l = 1'b0;
    logic       sin_r = 1'b0;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic [3:0] cnt;
    logic       drained;

    int total = 0;
    int bad = 0;

    // Reference model: register value as an integer 0..255, count as integer.
    int mq = 0;
    int mc = 0;
    logic pre_sout_r;

    always #5 clk = ~clk;

    dff_shift_reg #(.WIDTH(W), .RST_VAL(RV)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l), .sout_r(sout_r),
        .cnt(cnt), .drained(drained)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_q"}, {24'd0, q}, mq);
        check({tag, "_cnt"}, {28'd0, cnt}, mc);
        check({tag, "_drained"}, {31'd0, drained}, (mc == W) ? 1 : 0);
        check({tag, "_sout_l"}, {31'd0, sout_l}, (mq / 128) % 2);
        check({tag, "_sout_r"}, {31'd0, sout_r}, mq % 2);
    endtask

    // Behavioural effect of one enabled/disabled edge, in arithmetic terms.
    task automatic model_edge(input logic e, input logic [2:0] m, input logic [7:0] dd,
                              input logic sl, input logic sr);
        int v;
        if (!e) return;
        v = mq;
        case (int'(m))
            0: ;
            1: begin v = int'(dd); mc = 0; end
            2: begin v = (v * 2 + int'(sl)) % 256; mc = (mc < W) ? mc + 1 : W; end
            3: begin v = v / 2 + 128 * int'(sr); mc = (mc < W) ? mc + 1 : W; end
            4: v = (v * 2) % 256 + v / 128;
            5: v = v / 2 + 128 * (v % 2);
            6: begin v = 0; mc = 0; end
            default: begin v = 255; mc = 0; end
        endcase
        mq = v;
    endtask

    task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dd,
                        input logic sl, input logic sr, input bit mid_rst);
        @(negedge clk);
        en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
        if (mid_rst) begin
            #1 rst = 1'b1;
            #1;
            mq = int'(RV); mc = 0;
            check_all("mid_rst");
            rst = 1'b0;
        end
        pre_sout_r = sout_r;
        check("pre_sout_l", {31'd0, sout_l}, (mq / 128) % 2);
        check("pre_sout_r", {31'd0, sout_r}, mq % 2);
        @(posedge clk);
        model_edge(e, m, dd, sl, sr);
        #1 check_all("post");
    endtask

    initial begin
        logic exp_sr [8];
        logic in_l [8];
        exp_sr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        in_l   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // 1. Asynchronous reset between edges, then load after release.
        #3 rst = 1'b1;
        #1;
        mq = int'(RV); mc = 0;
        check("rst_async_q", {24'd0, q}, 32'hA5);
        check_all("rst");
        en = 1'b1; mode = LOAD; d = 8'h3C;
        @(posedge clk);
        #1 check("rst_holds_q", {24'd0, q}, 32'hA5);
        check("rst_holds_cnt", {28'd0, cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_edge(1'b1, LOAD, 8'h3C, 1'b0, 1'b0);
        #1 check("t1_load_q", {24'd0, q}, 32'h3C);
        check_all("t1");

        // 2. Serial shift out on sout_r.
        step(1'b1, LOAD, 8'h81, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, SHR, 8'h00, 1'b0, 1'b0, 1'b0);
            check("t2_sout_r_seq", {31'd0, pre_sout_r}, {31'd0, exp_sr[i]});
        end
        check("t2_q", {24'd0, q}, 32'h00);
        check("t2_cnt", {28'd0, cnt}, 8);
        check("t2_drained", {31'd0, drained}, 1);
        step(1'b1, SHR, 8'h00, 1'b0, 1'b0, 1'b0);
        check("t2_cnt_sat", {28'd0, cnt}, 8);

        // 3. Serial shift in from sin_l.
        step(1'b1, CLR, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, SHL, 8'h00, in_l[i], 1'b0, 1'b0);
        check("t3_q", {24'd0, q}, 32'hB2);
        check("t3_drained", {31'd0, drained}, 1);

        // 4. Rotates leave the counter alone.
        step(1'b1, LOAD, 8'h81, 1'b0, 1'b0, 1'b0);
        step(1'b1, ROL, 8'h00, 1'b1, 1'b1, 1'b0);
        check("t4_rol_q", {24'd0, q}, 32'h03);
        step(1'b1, ROR, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, ROR, 8'h00, 1'b1, 1'b1, 1'b0);
        check("t4_ror_q", {24'd0, q}, 32'hC0);
        check("t4_cnt", {28'd0, cnt}, 0);

        // 5. Enable gating.
        step(1'b1, LOAD, 8'h0F, 1'b0, 1'b0, 1'b0);
        step(1'b1, SHL, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, SET, 8'hFF, 1'b1, 1'b1, 1'b0);
        check("t5_gated_q", {24'd0, q}, 32'h1F);
        check("t5_gated_cnt", {28'd0, cnt}, 1);
        step(1'b1, SET, 8'hFF, 1'b0, 1'b0, 1'b0);
        check("t5_set_q", {24'd0, q}, 32'hFF);
        check("t5_set_cnt", {28'd0, cnt}, 0);

        // 6. Load clears a partial count.
        for (int i = 0; i < 3; i++) step(1'b1, SHL, 8'h00, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("t6_cnt3", {28'd0, cnt}, 3);
        step(1'b1, LOAD, 8'h55, 1'b0, 1'b0, 1'b0);
        check("t6_q", {24'd0, q}, 32'h55);
        check("t6_cnt", {28'd0, cnt}, 0);
        check("t6_drained", {31'd0, drained}, 0);

        // Reset in the middle of a shift sequence.
        for (int i = 0; i < 4; i++) step(1'b1, SHR, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, SHR, 8'h00, 1'b0, 1'b1, 1'b1);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) != 0),
                 3'($urandom_range(0, 7)),
                 8'($urandom),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dff_shift_reg
